scoreboard_hazard_unit: RTL and testbench

- Parametrised successor to the fixed load-use hazard detector in the 5-stage core.
- Tracks every in-flight register write with a per-register latency countdown, so EX units may take 1..MAX_LAT cycles.
- Sits at the ID/issue boundary: decides issue vs stall, drives bypass selects, enforces a single register-file write port.
- Replaces the combinational hazard/forwarding pair for multi-cycle units (mul/div, variable-latency loads).

---
 rtl/scoreboard_hazard_unit_if.sv | 45 ++++
 rtl/scoreboard_hazard_unit.sv | 119 +++++++++++
 tb/tb_scoreboard_hazard_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scoreboard_hazard_unit_if.sv
// ----------------------------------------------------------------------------
// scoreboard_hazard_unit_if
// Bundles the ID/issue-boundary signals of the scoreboard hazard unit.
//   master : ID stage (drives the decoded instruction and flush, observes
//            stall/issue, bypass selects, completion and pending vector)
//   slave  : scoreboard_hazard_unit
// Signals:
//   id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wr_en,
//   id_lat, flush                      -> toward the hazard unit
//   stall, issue, fwd_a, fwd_b, wb_valid, wb_rd, pending -> from the unit
// ----------------------------------------------------------------------------
interface scoreboard_hazard_unit_if #(
   parameter int NREGS  = 32,
   parameter int REG_AW = 5,
   parameter int CW     = 3
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic [REG_AW-1:0] id_rd;
   logic              id_wr_en;
   logic [CW-1:0]     id_lat;
   logic              flush;
   logic              stall;
   logic              issue;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;
   logic              wb_valid;
   logic [REG_AW-1:0] wb_rd;
   logic [NREGS-1:0]  pending;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_wr_en, id_lat, flush,
      input  stall, issue, fwd_a, fwd_b, wb_valid, wb_rd, pending
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_wr_en, id_lat, flush,
      output stall, issue, fwd_a, fwd_b, wb_valid, wb_rd, pending
   );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// ----------------------------------------------------------------------------
// scoreboard_hazard_unit
// Issue-stage scoreboard: every in-flight register write carries a latency
// countdown, so execution units may take 1..MAX_LAT cycles. The unit decides
// issue vs stall (RAW, WAW and single write-port rules), drives the bypass
// selects and reports which tracked write completes at the next edge.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : synchronous, active-high; clears every counter
//   sb    : scoreboard_hazard_unit_if.slave (ID inputs, stall/issue,
//           fwd_a/fwd_b, wb_valid/wb_rd, pending)
// Configuration:
//   SCOREBOARD_FWD_EN : when defined, a source whose counter is 1 is ready
//                       and its fwd select is 01 (completion bus); when
//                       undefined, sources wait for counter 0 and the fwd
//                       selects are tied to 00.
// ----------------------------------------------------------------------------
module scoreboard_hazard_unit #(
   parameter int NREGS   = 32,
   parameter int REG_AW  = 5,
   parameter int MAX_LAT = 4,
   parameter int CW      = 3
) (
   input logic                     clk,
   input logic                     reset,
   scoreboard_hazard_unit_if.slave sb
);

   // Per-register cycles until the pending write lands; 0 means idle.
   logic [CW-1:0] cnt [NREGS];

   logic [CW-1:0] lat_eff;
   logic [CW-1:0] cnt_a, cnt_b, cnt_d;
   logic          busy_a, busy_b;
   logic          wr_tracked;
   logic          port_hit;
   logic          hazard;

   // ------------------------------------------------------------------------
   // Combinational hazard / bypass / completion decode
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any conditional update so
      // that no path leaves it unassigned and a latch is never inferred.
      lat_eff     = sb.id_lat;
      port_hit    = 1'b0;
      sb.wb_valid = 1'b0;
      sb.wb_rd    = '0;
      sb.pending  = '0;

      if (sb.id_lat == '0)
         lat_eff = CW'(1);
      else if (sb.id_lat > CW'(MAX_LAT))
         lat_eff = CW'(MAX_LAT);

      cnt_a = cnt[sb.id_rs1];
      cnt_b = cnt[sb.id_rs2];
      cnt_d = cnt[sb.id_rd];

`ifdef SCOREBOARD_FWD_EN
      // A count of 1 means the result is on the completion bus right now.
      busy_a = sb.id_use_rs1 && (sb.id_rs1 != '0) && (cnt_a > CW'(1));
      busy_b = sb.id_use_rs2 && (sb.id_rs2 != '0) && (cnt_b > CW'(1));
      sb.fwd_a = (sb.id_use_rs1 && (sb.id_rs1 != '0) && (cnt_a == CW'(1)))
                 ? 2'b01 : 2'b00;
      sb.fwd_b = (sb.id_use_rs2 && (sb.id_rs2 != '0) && (cnt_b == CW'(1)))
                 ? 2'b01 : 2'b00;
`else
      busy_a = sb.id_use_rs1 && (sb.id_rs1 != '0) && (cnt_a != '0);
      busy_b = sb.id_use_rs2 && (sb.id_rs2 != '0) && (cnt_b != '0);
      sb.fwd_a = 2'b00;
      sb.fwd_b = 2'b00;
`endif

      // A new write lands after lat_eff edges; any counter now at
      // lat_eff+1 would land on the same cycle and collide on the port.
      for (int r = 1; r < NREGS; r++) begin
         if (cnt[r] == lat_eff + CW'(1))
            port_hit = 1'b1;
         if (cnt[r] == CW'(1)) begin
            sb.wb_valid = 1'b1;
            sb.wb_rd    = REG_AW'(r);
         end
         sb.pending[r] = (cnt[r] != '0);
      end

      wr_tracked = sb.id_wr_en && (sb.id_rd != '0);
      hazard     = sb.id_valid &&
                   (busy_a || busy_b ||
                    (wr_tracked && (cnt_d > lat_eff)) ||
                    (wr_tracked && port_hit));

      // Outputs are held quiet while reset is asserted.
      sb.stall = hazard && !sb.flush && !reset;
      sb.issue = sb.id_valid && !hazard && !sb.flush && !reset;
   end

   // ------------------------------------------------------------------------
   // Counter update: decrement everything, then the issuing write reloads
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the counter array is small control state, not a RAM, so
         // every entry is reset; stale counts would fabricate hazards.
         for (int r = 0; r < NREGS; r++)
            cnt[r] <= '0;
      end else begin
         cnt[0] <= '0;
         for (int r = 1; r < NREGS; r++)
            if (cnt[r] != '0)
               // NOTE: non-blocking assignment so the later load of the same
               // entry simply wins and all reads see pre-edge values.
               cnt[r] <= cnt[r] - CW'(1);
         if (sb.issue && wr_tracked)
            cnt[sb.id_rd] <= lat_eff;
      end
   end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// ----------------------------------------------------------------------------
// tb_scoreboard_hazard_unit
// Self-checking bench for scoreboard_hazard_unit. Each issued write pushes
// its expected completion (cycle, register) into a queue; a monitor pops and
// compares it against wb_valid/wb_rd every cycle. Scenario tasks check
// stall/issue/fwd/pending inline. Works with or without SCOREBOARD_FWD_EN.
// ----------------------------------------------------------------------------
module tb_scoreboard_hazard_unit;
   localparam int NREGS   = 32;
   localparam int REG_AW  = 5;
   localparam int MAX_LAT = 4;
   localparam int CW      = 3;

`ifdef SCOREBOARD_FWD_EN
   localparam int         RAW_STALLS = 2;
   localparam logic [1:0] FWD_EXP    = 2'b01;
`else
   localparam int         RAW_STALLS = 3;
   localparam logic [1:0] FWD_EXP    = 2'b00;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   scoreboard_hazard_unit_if #(.NREGS(NREGS), .REG_AW(REG_AW), .CW(CW)) bus ();

   scoreboard_hazard_unit #(
      .NREGS(NREGS), .REG_AW(REG_AW), .MAX_LAT(MAX_LAT), .CW(CW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .sb   (bus)
   );

   typedef struct {
      int          cyc;
      logic [4:0]  rd;
   } wb_exp_t;

   wb_exp_t exp_q[$];
   int      vectors = 0;
   int      miscompares = 0;
   int      cyc = 0;
   bit      mon_en = 1'b0;
   int      mon_hit;

   always @(posedge clk) cyc <= cyc + 1;

   // Completion scoreboard: exactly the expected writes, on their cycles.
   always @(negedge clk) begin
      if (mon_en) begin
         mon_hit = -1;
         foreach (exp_q[i])
            if (exp_q[i].cyc == cyc) mon_hit = i;
         vectors++;
         if (mon_hit >= 0) begin
            if (bus.wb_valid !== 1'b1 || bus.wb_rd !== exp_q[mon_hit].rd) begin
               miscompares++;
               $display("FAIL wb_complete cyc=%0d: got valid=%b rd=%0d, want valid=1 rd=%0d",
                        cyc, bus.wb_valid, bus.wb_rd, exp_q[mon_hit].rd);
            end
            exp_q.delete(mon_hit);
         end else if (bus.wb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wb_idle cyc=%0d: got valid=%b rd=%0d, want valid=0",
                     cyc, bus.wb_valid, bus.wb_rd);
         end
      end
   end

   function automatic int clamp_lat(input int l);
      if (l == 0) return 1;
      if (l > MAX_LAT) return MAX_LAT;
      return l;
   endfunction

   task automatic idle();
      bus.id_valid   = 1'b0;
      bus.id_rs1     = '0;
      bus.id_rs2     = '0;
      bus.id_use_rs1 = 1'b0;
      bus.id_use_rs2 = 1'b0;
      bus.id_rd      = '0;
      bus.id_wr_en   = 1'b0;
      bus.id_lat     = '0;
      bus.flush      = 1'b0;
   endtask

   task automatic drain(input int n);
      idle();
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Presents one instruction until it issues; returns stall cycles (-1 on
   // budget expiry) and the bypass selects seen in the issuing cycle.
   task automatic send(input logic [4:0] rd, input int lat, input logic wr,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       output int stalls, output logic [1:0] fa,
                       output logic [1:0] fb);
      bit done = 1'b0;
      bus.id_valid   = 1'b1;
      bus.id_rd      = rd;
      bus.id_lat     = 3'(lat);
      bus.id_wr_en   = wr;
      bus.id_rs1     = rs1;
      bus.id_use_rs1 = u1;
      bus.id_rs2     = rs2;
      bus.id_use_rs2 = u2;
      bus.flush      = 1'b0;
      stalls = 0;
      fa = 2'bxx;
      fb = 2'bxx;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (bus.issue === 1'b1) begin
            done = 1'b1;
            fa = bus.fwd_a;
            fb = bus.fwd_b;
            if (wr && rd != 0) exp_q.push_back('{cyc + clamp_lat(lat), rd});
         end else begin
            stalls++;
         end
         @(posedge clk);
         #1;
      end
      if (!done) stalls = -1;
      idle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      bus.id_valid = 1'b1; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd5;
      @(negedge clk);
      vectors++;
      if (bus.stall !== 1'b0 || bus.issue !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_hold: got stall=%b issue=%b, want 0 0", bus.stall, bus.issue);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle();
      @(negedge clk);
      vectors++;
      if ({bus.stall, bus.issue, bus.fwd_a, bus.fwd_b, bus.wb_valid} !== 7'b0 ||
          bus.wb_rd !== 5'd0 || bus.pending !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_state: got stall=%b issue=%b fa=%b fb=%b wbv=%b wbrd=%0d pend=%h, want all zero",
                  bus.stall, bus.issue, bus.fwd_a, bus.fwd_b, bus.wb_valid, bus.wb_rd, bus.pending);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      int s; logic [1:0] fa, fb;
      send(5'd5, 3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, s, fa, fb);
      vectors++;
      if (s !== 0) begin
         miscompares++; $display("FAIL basic_issue: got stalls=%0d, want 0", s);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         vectors++;
         if (bus.pending[5] !== (k < 3) || bus.wb_valid !== (k == 2)) begin
            miscompares++;
            $display("FAIL basic_count k=%0d: got pend5=%b wbv=%b, want %b %b",
                     k, bus.pending[5], bus.wb_valid, (k < 3), (k == 2));
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_raw();
      int s; logic [1:0] fa, fb;
      send(5'd5, 3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, s, fa, fb);
      send(5'd0, 1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, s, fa, fb);
      vectors++;
      if (s !== RAW_STALLS || fa !== FWD_EXP) begin
         miscompares++;
         $display("FAIL raw_rs1: got stalls=%0d fwd_a=%b, want %0d %b", s, fa, RAW_STALLS, FWD_EXP);
      end
      drain(5);
      send(5'd6, 2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, s, fa, fb);
      send(5'd0, 1, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, s, fa, fb);
      vectors++;
      if (s !== RAW_STALLS - 1 || fb !== FWD_EXP || fa !== 2'b00) begin
         miscompares++;
         $display("FAIL raw_rs2: got stalls=%0d fwd_b=%b fwd_a=%b, want %0d %b 00",
                  s, fb, fa, RAW_STALLS - 1, FWD_EXP);
      end
      drain(5);
   endtask

   task automatic test_waw();
      int s; logic [1:0] fa, fb;
      send(5'd7, 4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, s, fa, fb);
      send(5'd7, 1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, s, fa, fb);
      vectors++;
      if (s !== 3) begin
         miscompares++; $display("FAIL waw_stall: got stalls=%0d, want 3", s);
      end
      drain(4);
   endtask

   task automatic test_port();
      int s; logic [1:0] fa, fb;
      send(5'd3, 3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, s, fa, fb);
      drain(1);
      send(5'd4, 1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, s, fa, fb);
      vectors++;
      if (s !== 1) begin
         miscompares++; $display("FAIL port_stall: got stalls=%0d, want 1", s);
      end
      drain(4);
   endtask

   task automatic test_clamp();
      int s; logic [1:0] fa, fb;
      send(5'd6, 0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, s, fa, fb);
      send(5'd8, 7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, s, fa, fb);
      vectors++;
      if (s !== 0) begin
         miscompares++; $display("FAIL clamp_issue: got stalls=%0d, want 0", s);
      end
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         vectors++;
         if (bus.pending[8] !== (k <= 4)) begin
            miscompares++;
            $display("FAIL clamp_count k=%0d: got pend8=%b, want %b", k, bus.pending[8], (k <= 4));
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_flush();
      int s; logic [1:0] fa, fb;
      send(5'd5, 3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, s, fa, fb);
      bus.id_valid = 1'b1; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd5;
      bus.id_wr_en = 1'b1; bus.id_rd = 5'd10; bus.id_lat = 3'd2; bus.flush = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.stall !== 1'b0 || bus.issue !== 1'b0 || bus.pending !== 32'h20) begin
         miscompares++;
         $display("FAIL flush_cycle: got stall=%b issue=%b pend=%h, want 0 0 00000020",
                  bus.stall, bus.issue, bus.pending);
      end
      @(posedge clk);
      #1;
      idle();
      @(negedge clk);
      vectors++;
      if (bus.pending !== 32'h20) begin
         miscompares++;
         $display("FAIL flush_noload: got pend=%h, want 00000020", bus.pending);
      end
      drain(4);
   endtask

   task automatic test_zero_and_mid_reset();
      int s; logic [1:0] fa, fb;
      send(5'd0, 4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, s, fa, fb);
      @(negedge clk);
      vectors++;
      if (s !== 0 || bus.pending !== 32'h0) begin
         miscompares++;
         $display("FAIL zero_rd: got stalls=%0d pend=%h, want 0 00000000", s, bus.pending);
      end
      @(posedge clk);
      #1;
      send(5'd9, 4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, s, fa, fb);
      drain(2);
      exp_q.delete();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.id_valid = 1'b1; bus.id_use_rs1 = 1'b1; bus.id_rs1 = 5'd9;
      @(negedge clk);
      vectors++;
      if (bus.pending !== 32'h0 || bus.wb_valid !== 1'b0 || bus.stall !== 1'b0 || bus.issue !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_reset: got pend=%h wbv=%b stall=%b issue=%b, want 00000000 0 0 1",
                  bus.pending, bus.wb_valid, bus.stall, bus.issue);
      end
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic test_back_to_back();
      int s; logic [1:0] fa, fb;
      for (int r = 1; r <= 3; r++) begin
         send(5'(r), 1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, s, fa, fb);
         vectors++;
         if (s !== 0) begin
            miscompares++; $display("FAIL b2b_issue r=%0d: got stalls=%0d, want 0", r, s);
         end
      end
      send(5'd11, 2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, s, fa, fb);
      send(5'd12, 1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, s, fa, fb);
      vectors++;
      if (s !== 1) begin
         miscompares++; $display("FAIL b2b_port: got stalls=%0d, want 1", s);
      end
      drain(5);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      mon_en = 1'b1;
      test_basic();
      test_raw();
      test_waw();
      test_port();
      test_clamp();
      test_flush();
      test_zero_and_mid_reset();
      test_back_to_back();
      mon_en = 1'b0;
      vectors++;
      if (exp_q.size() !== 0) begin
         miscompares++;
         $display("FAIL wb_leftover: got %0d outstanding completions, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
